// File: rtl/fetch_unit.sv
// Program-counter sequencer that fronts the instruction ROM: issues one ROM load strobe, then
// steps the fetch address through halt/stall/jump/branch/increment until the program halts.
//
// state  | meaning
// IDLE   | waiting for start; PC parked at 0
// LOAD   | one-cycle romStart strobe; PC at 0
// RUN    | fetching; fetchValid high, PC advances by priority rules
// DONE   | halted; PC holds halt address until start drops
module fetch_unit #(
  parameter int D  = 12,
  parameter int OW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          halt,
  input  logic          stall,
  input  logic          jumpEn,
  input  logic [D-1:0]  jumpTarget,
  input  logic          branchEn,
  input  logic [OW-1:0] branchOffset,
  output logic [D-1:0]  programCounter,
  output logic          romStart,
  output logic          fetchValid,
  output logic          done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t       state_q, state_d;
  logic [D-1:0] pc_q, pc_d;
  logic         rom_start_q, rom_start_d;
  logic         fetch_valid_q, fetch_valid_d;
  logic         done_q, done_d;
  logic [D-1:0] branch_off_ext;

  // Sign-extend to PC width; the add below then wraps modulo 2^D in both directions.
  assign branch_off_ext = D'($signed(branchOffset));

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      S_IDLE: begin
        pc_d = '0;
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        pc_d    = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (halt) begin
          state_d = S_DONE;
        end else if (stall) begin
          pc_d = pc_q;
        end else if (jumpEn) begin
          pc_d = jumpTarget;
        end else if (branchEn) begin
          pc_d = pc_q + branch_off_ext;
        end else begin
          pc_d = pc_q + 1'b1;
        end
      end
      S_DONE: begin
        // Waiting for start to drop keeps a held start from re-running the program.
        if (!start) begin
          state_d = S_IDLE;
          pc_d    = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        pc_d    = '0;
      end
    endcase

    rom_start_d   = (state_d == S_LOAD);
    fetch_valid_d = (state_d == S_RUN);
    done_d        = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      pc_q          <= '0;
      rom_start_q   <= 1'b0;
      fetch_valid_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      rom_start_q   <= rom_start_d;
      fetch_valid_q <= fetch_valid_d;
      done_q        <= done_d;
    end
  end

  assign programCounter = pc_q;
  assign romStart       = rom_start_q;
  assign fetchValid     = fetch_valid_q;
  assign done           = done_q;

endmodule
